// File: rtl/glitch_pkg.sv
// Shared types for the multi-slot glitch sequencer: slot modes, FSM states and slot config.
package glitch_pkg;

    // Upper bounds for the per-instance delay and width parameters.
    localparam int DELAY_W_MAX = 32;
    localparam int WIDTH_W_MAX = 8;

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        LOW    = 2'd1,
        HIGH   = 2'd2,
        INVERT = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        WAIT   = 2'd2,
        GLITCH = 2'd3
    } state_t;

    typedef struct packed {
        logic [DELAY_W_MAX-1:0] delay;
        logic [WIDTH_W_MAX-1:0] width;
        mode_t                  mode;
    } slot_cfg_t;

endpackage

// File: rtl/trig_sync.sv
// Synchroniser for an asynchronous trigger plus a registered one-cycle rising-edge pulse.
module trig_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic                   pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], d};
        pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/glitch_sequencer.sv
// Trigger-driven sequencer that alters the target clock in up to NUM_SLOTS programmable windows.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int NUM_SLOTS   = 4,
    parameter int DELAY_W     = 32,
    parameter int WIDTH_W     = 8,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int CNT_W      = $clog2(NUM_SLOTS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clean_target_clock,
    input  logic               trig,
    input  logic               arm,
    input  logic               abort,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  mode_t              cfg_mode,
    input  logic [CNT_W-1:0]   cfg_count,
    output logic               clk_o,
    output logic               armed,
    output logic               busy,
    output logic               done,
    output logic               glitch_active,
    output logic [IDX_W-1:0]   slot_idx
);

    state_t             state_q, state_d;
    slot_cfg_t          slots_q [NUM_SLOTS];
    slot_cfg_t          slots_d [NUM_SLOTS];
    logic [IDX_W-1:0]   slot_idx_q, slot_idx_d, next_idx;
    logic [CNT_W-1:0]   n_active_q, n_active_d;
    logic [DELAY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [WIDTH_W-1:0] wid_cnt_q, wid_cnt_d, cur_w;
    logic               ctc_q;
    logic               glitch_active_q, glitch_active_d;
    logic               done_q, done_d;
    logic               trig_edge, tedge, cfg_open, count_ok, more_slots;
    slot_cfg_t          cur_slot, nxt_slot;

    trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (trig),
        .pulse (trig_edge)
    );

    // clean_target_clock is generated from clk, so a plain registered copy is enough.
    assign tedge      = clean_target_clock & ~ctc_q;
    assign next_idx   = slot_idx_q + IDX_W'(1);
    assign cur_slot   = slots_q[slot_idx_q];
    assign nxt_slot   = slots_q[next_idx];
    assign cur_w      = WIDTH_W'(cur_slot.width);
    assign cfg_open   = (state_q == IDLE) || (state_q == ARMED);
    assign count_ok   = (cfg_count != '0) && (32'(cfg_count) <= NUM_SLOTS);
    assign more_slots = (CNT_W'(slot_idx_q) + CNT_W'(1)) < n_active_q;

    always_comb begin
        slots_d = slots_q;
        if (cfg_we && cfg_open && (32'(cfg_idx) < NUM_SLOTS))
            slots_d[cfg_idx] = '{delay: DELAY_W_MAX'(cfg_delay),
                                 width: WIDTH_W_MAX'(cfg_width),
                                 mode:  cfg_mode};
    end

    always_comb begin
        state_d    = state_q;
        slot_idx_d = slot_idx_q;
        n_active_d = n_active_q;
        dly_cnt_d  = dly_cnt_q;
        wid_cnt_d  = wid_cnt_q;
        done_d     = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (arm && count_ok) begin
                    n_active_d = cfg_count;
                    state_d    = ARMED;
                end
                ARMED: if (trig_edge) begin
                    slot_idx_d = '0;
                    dly_cnt_d  = DELAY_W'(slots_q[0].delay);
                    state_d    = WAIT;
                end
                WAIT: begin
                    // The tedge that takes the count to zero starts the glitch on the next cycle.
                    if (dly_cnt_q == '0 || (dly_cnt_q == DELAY_W'(1) && tedge)) begin
                        state_d   = GLITCH;
                        wid_cnt_d = (cur_w == '0) ? '0 : cur_w - WIDTH_W'(1);
                    end else if (tedge) begin
                        dly_cnt_d = dly_cnt_q - DELAY_W'(1);
                    end
                end
                GLITCH: begin
                    if (wid_cnt_q == '0) begin
                        if (more_slots) begin
                            slot_idx_d = next_idx;
                            dly_cnt_d  = DELAY_W'(nxt_slot.delay);
                            state_d    = WAIT;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        wid_cnt_d = wid_cnt_q - WIDTH_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        glitch_active_d = (state_d == GLITCH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            slot_idx_q      <= '0;
            n_active_q      <= '0;
            dly_cnt_q       <= '0;
            wid_cnt_q       <= '0;
            ctc_q           <= 1'b0;
            glitch_active_q <= 1'b0;
            done_q          <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
        end else begin
            state_q         <= state_d;
            slot_idx_q      <= slot_idx_d;
            n_active_q      <= n_active_d;
            dly_cnt_q       <= dly_cnt_d;
            wid_cnt_q       <= wid_cnt_d;
            ctc_q           <= clean_target_clock;
            glitch_active_q <= glitch_active_d;
            done_q          <= done_d;
            for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= slots_d[i];
        end
    end

    // Selects are registered, so clk_o only switches source at clk edges.
    always_comb begin
        clk_o = clean_target_clock;
        if (glitch_active_q) begin
            case (cur_slot.mode)
                LOW:     clk_o = 1'b0;
                HIGH:    clk_o = 1'b1;
                INVERT:  clk_o = ~clean_target_clock;
                default: clk_o = clean_target_clock;
            endcase
        end
    end

    assign armed         = (state_q == ARMED);
    assign busy          = (state_q == WAIT) || (state_q == GLITCH);
    assign done          = done_q;
    assign glitch_active = glitch_active_q;
    assign slot_idx      = slot_idx_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomised bench: per-run glitch schedule computed from slot configs and the divided-clock waveform.
module tb_glitch_sequencer;
    import glitch_pkg::*;

    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int WW   = 8;
    localparam int SS   = 2;
    localparam int MAXC = 16384;

    logic          clk = 1'b0, rst = 1'b0, ctc = 1'b0, trig = 1'b0;
    logic          arm = 1'b0, abort = 1'b0, cfg_we = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic [DW-1:0] cfg_delay = '0;
    logic [WW-1:0] cfg_width = '0;
    mode_t         cfg_mode = PASS;
    logic [2:0]    cfg_count = '0;
    logic          clk_o, armed, busy, done, glitch_active;
    logic [1:0]    slot_idx;

    glitch_sequencer #(.NUM_SLOTS(NS), .DELAY_W(DW), .WIDTH_W(WW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .clean_target_clock(ctc), .trig(trig), .arm(arm), .abort(abort),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
        .cfg_mode(cfg_mode), .cfg_count(cfg_count), .clk_o(clk_o), .armed(armed), .busy(busy),
        .done(done), .glitch_active(glitch_active), .slot_idx(slot_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc = 0, div = 3, ph = 0;
    bit e_armed [MAXC];
    bit e_busy  [MAXC];
    bit e_done  [MAXC];
    bit e_ga    [MAXC];
    int e_idx   [MAXC];
    int e_md    [MAXC];
    int t_dly [NS];
    int t_wid [NS];
    int t_md  [NS];
    bit d_arm = 0, d_trig = 0, d_abort = 0, d_we = 0, d_rst_n = 0;
    int d_idx = 0, d_dly = 0, d_wid = 0, d_md = 0, d_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit ctc_at(input int c);
        return ((c + ph) % (2 * div)) < div;
    endfunction

    function automatic bit tedge_at(input int c);
        return ctc_at(c) && !ctc_at(c - 1);
    endfunction

    function automatic void clr(input int c);
        e_armed[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_ga[c] = 0;
    endfunction

    // One clk cycle: drive, let combinational paths settle, compare, advance.
    task automatic step();
        bit ec;
        ctc = ctc_at(cyc); rst = d_rst_n; arm = d_arm; trig = d_trig; abort = d_abort;
        cfg_we = d_we; cfg_idx = 2'(d_idx); cfg_delay = DW'(d_dly); cfg_width = WW'(d_wid);
        cfg_mode = mode_t'(d_md); cfg_count = 3'(d_cnt);
        #1;
        ec = ctc;
        if (e_ga[cyc]) begin
            case (e_md[cyc])
                1: ec = 1'b0;
                2: ec = 1'b1;
                3: ec = ~ctc;
                default: ec = ctc;
            endcase
        end
        chk("clk_o", clk_o, ec);
        chk("armed", armed, e_armed[cyc]);
        chk("busy", busy, e_busy[cyc]);
        chk("done", done, e_done[cyc]);
        chk("glitch_active", glitch_active, e_ga[cyc]);
        if (e_busy[cyc]) chk("slot_idx", slot_idx, e_idx[cyc]);
        if (!d_rst_n) begin
            for (int s = 0; s < NS; s++) begin t_dly[s] = 0; t_wid[s] = 0; t_md[s] = 0; end
        end else if (d_we && !e_busy[cyc] && d_idx < NS) begin
            t_dly[d_idx] = d_dly; t_wid[d_idx] = d_wid; t_md[d_idx] = d_md;
        end
        d_arm = 0; d_abort = 0; d_we = 0;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic cfg_wr(input int i, input int d, input int w, input int m);
        d_we = 1; d_idx = i; d_dly = d; d_wid = w; d_md = m;
        step();
    endtask

    // Plans the whole run from the slot table, then drives it cycle by cycle.
    task automatic do_run(input int cnt, input int ab_slot, input bit we_busy, input bit rst_glitch);
        int a, t, w, g, ww, c, k, last, ab_cyc, we_cyc, rs_cyc;
        bit valid;
        a = cyc;
        t = a + 1 + int'($urandom_range(0, 3));
        valid = (cnt >= 1) && (cnt <= NS);
        ab_cyc = -1; we_cyc = -1; rs_cyc = -1;
        last = t + SS + 2;
        if (valid) begin
            for (c = a + 1; c <= t + SS + 1; c++) e_armed[c] = 1;
            w = t + SS + 2;
            for (int s = 0; s < cnt; s++) begin
                if (s == ab_slot) ab_cyc = w;
                if (we_busy && s == 0) we_cyc = w;
                if (t_dly[s] == 0) begin
                    g = w + 1;
                end else begin
                    c = w - 1; k = 0;
                    while (k < t_dly[s] && c < MAXC - 2) begin
                        c++;
                        if (tedge_at(c)) k++;
                    end
                    g = c + 1;
                end
                ww = (t_wid[s] == 0) ? 1 : t_wid[s];
                for (c = w; c < g + ww; c++) begin e_busy[c] = 1; e_idx[c] = s; end
                for (c = g; c < g + ww; c++) begin e_ga[c] = 1; e_md[c] = t_md[s]; end
                if (rst_glitch && s == 0) rs_cyc = g;
                w = g + ww;
            end
            e_done[w] = 1;
            last = w;
        end
        if (ab_cyc >= 0) for (c = ab_cyc + 1; c <= last; c++) clr(c);
        if (rs_cyc >= 0) for (c = rs_cyc; c <= last; c++) clr(c);
        for (c = a; c <= last + SS + 3; c++) begin
            d_arm   = (c == a);
            d_cnt   = cnt;
            d_trig  = (c >= t) && (c <= last) && !(rs_cyc >= 0 && c >= rs_cyc);
            d_abort = (c == ab_cyc);
            d_rst_n = !(rs_cyc >= 0 && c >= rs_cyc && c < rs_cyc + 2);
            if (c == we_cyc) begin d_we = 1; d_idx = 0; d_dly = 99; d_wid = 1; d_md = 1; end
            step();
        end
        d_rst_n = 1;
    endtask

    initial begin
        int cnt, ab;
        for (int s = 0; s < NS; s++) begin t_dly[s] = 0; t_wid[s] = 0; t_md[s] = 0; end
        @(posedge clk); #1;
        d_rst_n = 0;
        repeat (3) step();
        d_rst_n = 1;
        repeat (12) step();

        cfg_wr(0, 5, 2, 1);
        do_run(1, -1, 0, 0);

        cfg_wr(0, 0, 1, 2); cfg_wr(1, 2, 3, 3); cfg_wr(2, 1, 1, 0);
        do_run(3, -1, 0, 0);
        do_run(3, 1, 0, 0);

        cfg_wr(0, 3, 2, 1);
        do_run(1, -1, 1, 0);
        do_run(1, -1, 0, 0);
        do_run(0, -1, 0, 0);
        do_run(5, -1, 0, 0);

        cfg_wr(0, 2, 4, 2);
        do_run(1, -1, 0, 1);
        do_run(1, -1, 0, 0);

        for (int r = 0; r < 30 && cyc < MAXC - 600; r++) begin
            div = int'($urandom_range(2, 4));
            ph  = int'($urandom_range(0, 7));
            for (int s = 0; s < NS; s++)
                if ($urandom_range(0, 1) == 1)
                    cfg_wr(s, int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                           int'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) cnt = ($urandom_range(0, 1) == 1) ? 0 : 5;
            else cnt = int'($urandom_range(1, 4));
            ab = -1;
            if (cnt >= 1 && cnt <= NS && $urandom_range(0, 4) == 0)
                ab = int'($urandom_range(0, cnt - 1));
            do_run(cnt, ab, $urandom_range(0, 4) == 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
